// File: rtl/branch_predictor.sv
// Bimodal branch predictor: table of 2-bit saturating counters indexed by PC,
// registered prediction to fetch, and mispredict/redirect back to fetch.
module branch_predictor #(
    parameter int         ENTRIES  = 64,
    parameter int         INDEX_W  = $clog2(ENTRIES),
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        ready_o,

    input  logic        pred_valid_i,
    input  logic [31:0] pred_pc_i,
    output logic        pred_valid_o,
    output logic        pred_taken_o,

    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_taken_i,
    input  logic        upd_pred_i,
    input  logic [31:0] upd_target_i,
    output logic        mispredict_o,
    output logic [31:0] redirect_pc_o,
    output logic [15:0] mispred_cnt_o
);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [INDEX_W-1:0] sweep_idx_q;
    logic [INDEX_W-1:0] sweep_idx_d;
    logic               sweep_we;

    logic [1:0]         table_q [ENTRIES];

    logic [INDEX_W-1:0] pred_idx;
    logic [INDEX_W-1:0] upd_idx;
    logic [1:0]         upd_ctr;
    logic [1:0]         upd_ctr_next;
    logic               upd_we;
    logic               run;

    logic               mispredict_d;
    logic [31:0]        redirect_pc_d;

    // PC bits outside the index only alias entries; they carry no state.
    logic               unused_pc_bits;

    assign pred_idx = pred_pc_i[INDEX_W+1:2];
    assign upd_idx  = upd_pc_i[INDEX_W+1:2];
    assign unused_pc_bits = ^{pred_pc_i[31:INDEX_W+2], pred_pc_i[1:0],
                              upd_pc_i[31:INDEX_W+2], upd_pc_i[1:0]};

    assign run     = (state_q == S_RUN);
    assign ready_o = run;

    // Sweep state register: reset restarts the sweep from entry 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_INIT;
            sweep_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
        end
    end

    // Sweep next-state: one entry per cycle, then park in RUN until reset.
    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        sweep_we    = 1'b0;
        unique case (state_q)
            S_INIT: begin
                sweep_we    = 1'b1;
                sweep_idx_d = sweep_idx_q + 1'b1;
                if (sweep_idx_q == INDEX_W'(ENTRIES - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // Saturating counter step for the resolved branch.
    always_comb begin
        upd_ctr      = table_q[upd_idx];
        upd_ctr_next = upd_ctr;
        upd_we       = run && upd_valid_i;
        if (upd_taken_i) begin
            if (upd_ctr != 2'b11) begin
                upd_ctr_next = upd_ctr + 2'b01;
            end
        end else begin
            if (upd_ctr != 2'b00) begin
                upd_ctr_next = upd_ctr - 2'b01;
            end
        end
    end

    // Counter table: sweep writes during INIT, training writes during RUN.
    // Nothing is written while reset is held, so in-flight updates drop.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (sweep_we) begin
                table_q[sweep_idx_q] <= CTR_INIT;
            end else if (upd_we) begin
                table_q[upd_idx] <= upd_ctr_next;
            end
        end
    end

    // Registered prediction; reads the pre-update counter on a collision.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pred_valid_o <= 1'b0;
            pred_taken_o <= 1'b0;
        end else begin
            pred_valid_o <= pred_valid_i;
            if (pred_valid_i) begin
                pred_taken_o <= run ? table_q[pred_idx][1] : 1'b0;
            end
        end
    end

    // Mispredict decision and the corrected fetch address.
    always_comb begin
        mispredict_d  = upd_valid_i && (upd_taken_i != upd_pred_i);
        redirect_pc_d = upd_taken_i ? upd_target_i : upd_pc_i + 32'd4;
    end

    // Mispredict pulse, held redirect address and saturating event count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mispredict_o  <= 1'b0;
            redirect_pc_o <= '0;
            mispred_cnt_o <= '0;
        end else begin
            mispredict_o <= mispredict_d;
            if (mispredict_d) begin
                redirect_pc_o <= redirect_pc_d;
                if (mispred_cnt_o != 16'hFFFF) begin
                    mispred_cnt_o <= mispred_cnt_o + 16'd1;
                end
            end
        end
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Bimodal branch history table (BHT) of 2-bit saturating counters, indexed by PC.
- Supplies a registered taken/not-taken prediction to fetch.
- Consumes the resolved branch outcome from the execute-stage branch condition generator; updates the table and raises a one-cycle mispredict/redirect pulse to fetch.
- After reset, sweeps the table to its initial value before accepting updates.

Parameters:
- ENTRIES, 64, number of BHT entries; power of two, at least 4.
- INDEX_W, $clog2(ENTRIES), index width; derived, not overridden.
- CTR_INIT, 2'b01, counter value written by the init sweep (weakly not-taken).

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous active-high reset.
- ready_o  output  1  high when the init sweep is complete and the table is valid.
- pred_valid_i  input  1  fetch requests a prediction this cycle.
- pred_pc_i  input  32  PC of the fetched instruction.
- pred_valid_o  output  1  prediction valid; registered copy of pred_valid_i.
- pred_taken_o  output  1  predicted direction; valid when pred_valid_o is high.
- upd_valid_i  input  1  a conditional branch resolved in execute this cycle.
- upd_pc_i  input  32  PC of the resolved branch.
- upd_taken_i  input  1  actual direction (branch condition generator taken output).
- upd_pred_i  input  1  prediction that travelled down the pipe with the branch.
- upd_target_i  input  32  branch target address (pc + imm), computed upstream.
- mispredict_o  output  1  one-cycle pulse: the resolved direction differs from the prediction.
- redirect_pc_o  output  32  correct next PC; valid when mispredict_o is high.
- mispred_cnt_o  output  16  saturating count of mispredicts since reset.

Behaviour:
- Reset values (rst_i high at a posedge) on the next edge:
  - ready_o=0, pred_valid_o=0, pred_taken_o=0.
  - mispredict_o=0, redirect_pc_o=0, mispred_cnt_o=0.
  - FSM enters INIT with sweep index 0.
- Reset asserted mid-operation aborts any in-flight update and restarts the sweep from index 0.
- FSM INIT:
  - Writes CTR_INIT to entry[idx] each cycle and increments idx.
  - After writing entry ENTRIES-1, moves to RUN; ready_o rises on that transition edge.
  - INIT lasts exactly ENTRIES cycles after rst_i deasserts.
- FSM RUN: terminal state; exits only on reset.
- Indexing: idx = pc[INDEX_W+1:2]. PC bits [1:0] and the upper bits are ignored, so aliasing is permitted.
- Prediction (1-cycle latency):
  - pred_valid_o <= pred_valid_i.
  - pred_taken_o <= ready ? entry[idx(pred_pc_i)][1] : 0.
  - In INIT, pred_taken_o is forced to 0.
  - pred_taken_o holds its last value when pred_valid_i is low.
- Update (RUN only; ignored in INIT for the table):
  - Taken: counter increments, saturating at 2'b11.
  - Not taken: counter decrements, saturating at 2'b00.
- Simultaneous prediction and update to the same index: the prediction uses the pre-update counter value (read-before-write). The new value is visible from the next cycle.
- Mispredict detection is independent of table state and is active in INIT and RUN:
  - When upd_valid_i=1 and upd_taken_i != upd_pred_i, the next edge sets mispredict_o=1.
  - redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + 4. The add is 32-bit modulo, so 0xFFFFFFFC+4 = 0x00000000.
  - Otherwise mispredict_o=0 next cycle.
  - redirect_pc_o holds its last value when no mispredict occurs.
- Back-to-back updates on consecutive cycles are each processed; mispredict_o can stay high for consecutive cycles.
- mispred_cnt_o increments on each cycle in which mispredict_o is set, and saturates at 16'hFFFF.
- There is no backpressure: every request and update is accepted in its cycle.

Test Plan:
- Reset then idle -> ready_o=0 for 64 cycles and rises on the 64th post-reset edge; a prediction for pc 0x100 returns pred_taken_o=0 (counter 01).
- Two taken updates at pc 0x100, then predict 0x100 -> pred_taken_o=1. Four more taken updates, then one not-taken -> still predicts 1 (counter 11 saturates, drops to 10).
- Update pc 0x200, upd_pred_i=0, upd_taken_i=1, target 0x80 -> next cycle mispredict_o=1, redirect_pc_o=0x80, mispred_cnt_o=1. Update pc 0x200, upd_pred_i=1, upd_taken_i=0 -> redirect_pc_o=0x204.
- Same-cycle prediction and taken update at pc 0x40 with counter 01 -> pred_taken_o=0. A prediction on the following cycle -> 1.
- Aliasing: update pc 0x0 and predict pc 0x100 (ENTRIES=64) -> both map to index 0 and share the counter. Not-taken mispredict at pc 0xFFFFFFFC -> redirect_pc_o=0x00000000.
- Assert rst_i during a mispredict pulse and after the table is trained -> outputs 0 next edge. The sweep reruns for 64 cycles, and the trained entries read back as 01.
